// File: rtl/neuron_mac_0_29.sv
// neuron_mac_0_29
// Computes one neuron output from a weight BRAM and a stream of input
// activations. The block reads one weight at a time (addresses 0..N_IN-1) and
// takes one activation per weight. It accumulates the signed products, adds the
// bias, shifts back to the operand format and saturates. An optional ReLU
// follows, and the result is held on a valid/ready output port.
//
// Ports
//   CLK, RST           clock (posedge) and synchronous active-high reset
//   START, BIAS        start a vector; BIAS is captured when START is accepted
//   BUSY               high whenever the block is not idle
//   W_ADDR, W_EN, W_WE weight BRAM address/enable (registered); write enable tied 0
//   W_DO               weight BRAM read data (the BRAM updates it on the negedge)
//   X_DATA, X_VALID    activation stream input
//   X_READY            activation stream ready (MAC state only)
//   Y_DATA, Y_VALID    neuron output, held until Y_READY
//   Y_READY            downstream accept
//   Y_OVF              result was clipped by saturation; valid with Y_VALID
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for START
// S_FETCH | W_EN/W_ADDR high for one cycle; BRAM drives W_DO on negedge
// S_MAC   | waiting for X_VALID, then accumulate X_DATA*W_DO
// S_FINAL | add bias, rescale, saturate, ReLU; register the result
// S_DONE  | Y_VALID high until Y_READY
module neuron_mac_0_29 #(
  parameter int N_IN      = 28,
  parameter int ADDR_W    = 5,
  parameter int D_W       = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter bit RELU      = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [D_W-1:0]    BIAS,
  output logic              BUSY,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W_EN,
  output logic              W_WE,
  input  logic [D_W-1:0]    W_DO,
  input  logic [D_W-1:0]    X_DATA,
  input  logic              X_VALID,
  output logic              X_READY,
  output logic [D_W-1:0]    Y_DATA,
  output logic              Y_VALID,
  input  logic              Y_READY,
  output logic              Y_OVF
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MAC,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0]       LAST  = ADDR_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2 ** (D_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  state_t                   state, state_n;
  logic [ADDR_W-1:0]        idx, idx_n;
  logic signed [ACC_W-1:0]  acc;
  logic [D_W-1:0]           bias_q;
  logic                     w_en_q;
  logic [ADDR_W-1:0]        w_addr_q;
  logic [D_W-1:0]           y_data_q;
  logic                     y_ovf_q;

  logic signed [2*D_W-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  t_sum;
  logic signed [ACC_W-1:0]  r_shift;
  logic                     sat_hi, sat_lo;
  logic [D_W-1:0]           res;

  // Next-state logic. idx only advances on a MAC handshake that is not the
  // last element, so it can never exceed N_IN-1.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_n = S_FETCH;
          idx_n   = '0;
        end
      end
      S_FETCH: state_n = S_MAC;
      S_MAC: begin
        if (X_VALID) begin
          if (idx == LAST) begin
            state_n = S_FINAL;
          end else begin
            idx_n   = idx + ADDR_W'(1);
            state_n = S_FETCH;
          end
        end
      end
      S_FINAL: state_n = S_DONE;
      S_DONE:  if (Y_READY) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: full-width signed product, bias aligned to the product's
  // fractional point, then an arithmetic (floor) shift back to D_W format.
  always_comb begin
    prod     = $signed(X_DATA) * $signed(W_DO);
    prod_ext = {{(ACC_W - 2*D_W){prod[2*D_W-1]}}, prod};
    bias_ext = {{(ACC_W - D_W){bias_q[D_W-1]}}, bias_q} <<< FRAC_BITS;
    t_sum    = acc + bias_ext;
    r_shift  = t_sum >>> FRAC_BITS;
    sat_hi   = (r_shift > MAX_V);
    sat_lo   = (r_shift < MIN_V);
    if (sat_hi) begin
      res = MAX_V[D_W-1:0];
    end else if (sat_lo) begin
      res = MIN_V[D_W-1:0];
    end else begin
      res = r_shift[D_W-1:0];
    end
    // ReLU acts on the value after clipping and leaves the overflow flag alone.
    if (RELU && r_shift[ACC_W-1]) begin
      res = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      idx      <= '0;
      acc      <= '0;
      bias_q   <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      y_data_q <= '0;
      y_ovf_q  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      // Address/enable are registered from next-state, so they are high
      // exactly while the state register holds S_FETCH.
      w_en_q <= (state_n == S_FETCH);
      if (state_n == S_FETCH) begin
        w_addr_q <= idx_n;
      end
      if (state == S_IDLE && START) begin
        acc    <= '0;
        bias_q <= BIAS;
      end
      if (state == S_MAC && X_VALID) begin
        acc <= acc + prod_ext;
      end
      if (state == S_FINAL) begin
        y_data_q <= res;
        y_ovf_q  <= sat_hi | sat_lo;
      end
      if (state == S_DONE && Y_READY) begin
        y_ovf_q <= 1'b0;
      end
    end
  end

  assign BUSY    = (state != S_IDLE);
  assign X_READY = (state == S_MAC);
  assign Y_VALID = (state == S_DONE);
  assign W_EN    = w_en_q;
  assign W_ADDR  = w_addr_q;
  assign W_WE    = 1'b0;
  assign Y_DATA  = y_data_q;
  assign Y_OVF   = y_ovf_q;

endmodule

// File: tb/tb_neuron_mac_0_29.sv
module tb_neuron_mac_0_29;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic        busy;
  logic [4:0]  w_addr;
  logic        w_en;
  logic        w_we;
  logic [15:0] w_do;
  logic [15:0] x_data;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_ready;
  logic        y_ovf;

  logic [15:0] mem [0:27];
  int          addr_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  neuron_mac_0_29 dut (
    .CLK(clk), .RST(rst), .START(start), .BIAS(bias), .BUSY(busy),
    .W_ADDR(w_addr), .W_EN(w_en), .W_WE(w_we), .W_DO(w_do),
    .X_DATA(x_data), .X_VALID(x_valid), .X_READY(x_ready),
    .Y_DATA(y_data), .Y_VALID(y_valid), .Y_READY(y_ready), .Y_OVF(y_ovf)
  );

  // Weight BRAM model: read on the falling edge when enabled.
  always @(negedge clk) begin
    if (w_en) w_do <= mem[w_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [15:0] w, input bit alt);
    for (int i = 0; i < 28; i++) mem[i] = (alt && (i % 2 == 1)) ? 16'hFF00 : w;
  endtask

  // Start a vector and stream activations until Y_VALID. A stall of stall_len
  // cycles is inserted once stall_at handshakes have been made. abort_at >= 0
  // returns as soon as that many handshakes have been made.
  task automatic run_vec(input logic [15:0] b, input logic [15:0] xv,
                         input int stall_at, input int stall_len, input int abort_at,
                         output int lat, output int wen_cnt, output int stall_wen);
    int hs = 0;
    int left = stall_len;
    bit stalling;
    lat = 0; wen_cnt = 0; stall_wen = 0;
    addr_q.delete();
    x_data = xv;
    bias = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bias = 16'hDEAD;
    forever begin
      if (abort_at >= 0 && hs == abort_at) break;
      stalling = 1'b0;
      if (x_ready && hs == stall_at && left > 0) begin
        stalling = 1'b1;
        left--;
      end
      if (w_en) begin
        wen_cnt++;
        addr_q.push_back(int'(w_addr));
        if (stalling) stall_wen++;
      end
      x_valid = ~stalling;
      if (x_ready && x_valid) hs++;
      @(posedge clk); #1;
      lat++;
      if (y_valid) break;
      if (lat > 300) begin
        chk("y_valid_timeout", 32'(y_valid), 32'd1);
        break;
      end
    end
    x_valid = 1'b0;
  endtask

  task automatic accept_y;
    y_ready = 1'b1;
    @(posedge clk); #1;
    y_ready = 1'b0;
    chk("y_valid_drop", 32'(y_valid), 32'd0);
    chk("y_ovf_drop", 32'(y_ovf), 32'd0);
    chk("idle_after_y", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, wc, sw;
    rst = 1'b1; start = 1'b0; bias = '0; x_data = '0; x_valid = 1'b0; y_ready = 1'b0;
    w_do = '0;
    fill(16'h0100, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_w_we", 32'(w_we), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_y_data", 32'(y_data), 32'd0);
    chk("rst_y_ovf", 32'(y_ovf), 32'd0);
    chk("rst_x_ready", 32'(x_ready), 32'd0);

    // 1: unit weights and activations
    fill(16'h0100, 1'b0);
    run_vec(16'h0000, 16'h0100, -1, 0, -1, lat, wc, sw);
    chk("c1_lat", 32'(lat), 32'd57);
    chk("c1_y_data", 32'(y_data), 32'h1C00);
    chk("c1_y_ovf", 32'(y_ovf), 32'd0);
    chk("c1_w_en_cnt", 32'(wc), 32'd28);
    accept_y();

    // 2: positive saturation, then negative saturation hidden by ReLU
    fill(16'h7FFF, 1'b0);
    run_vec(16'h7FFF, 16'h7FFF, -1, 0, -1, lat, wc, sw);
    chk("c2p_y_data", 32'(y_data), 32'h7FFF);
    chk("c2p_y_ovf", 32'(y_ovf), 32'd1);
    accept_y();
    fill(16'h8000, 1'b0);
    run_vec(16'h7FFF, 16'h7FFF, -1, 0, -1, lat, wc, sw);
    chk("c2n_y_data", 32'(y_data), 32'h0000);
    chk("c2n_y_ovf", 32'(y_ovf), 32'd1);
    accept_y();

    // 3: stall of 5 cycles at idx 10
    fill(16'h0100, 1'b0);
    run_vec(16'h0080, 16'h0200, 10, 5, -1, lat, wc, sw);
    chk("c3_lat", 32'(lat), 32'd62);
    chk("c3_y_data", 32'(y_data), 32'h3880);
    chk("c3_w_en_cnt", 32'(wc), 32'd28);
    chk("c3_stall_w_en", 32'(sw), 32'd0);
    accept_y();

    // 4: reset in the middle of a vector
    run_vec(16'h0000, 16'h0100, -1, 0, 10, lat, wc, sw);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("c4_busy", 32'(busy), 32'd0);
    chk("c4_w_en", 32'(w_en), 32'd0);
    chk("c4_y_valid", 32'(y_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("c4_no_y", 32'(y_valid), 32'd0);
    run_vec(16'h0000, 16'h0100, -1, 0, -1, lat, wc, sw);
    chk("c4_lat", 32'(lat), 32'd57);
    chk("c4_y_data", 32'(y_data), 32'h1C00);
    chk("c4_y_ovf", 32'(y_ovf), 32'd0);

    // 5: hold Y for 10 cycles with START pulses, START also on the handshake
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 1);
      @(posedge clk); #1;
      start = 1'b0;
      chk("c5_y_valid_hold", 32'(y_valid), 32'd1);
      chk("c5_y_data_hold", 32'(y_data), 32'h1C00);
    end
    start = 1'b1;
    y_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    y_ready = 1'b0;
    chk("c5_busy_after", 32'(busy), 32'd0);
    chk("c5_y_valid_after", 32'(y_valid), 32'd0);
    @(posedge clk); #1;
    chk("c5_still_idle", 32'(busy), 32'd0);

    // 6: alternating weights cancel; check address sequence
    fill(16'h0100, 1'b1);
    run_vec(16'h0000, 16'h0300, -1, 0, -1, lat, wc, sw);
    chk("c6_y_data", 32'(y_data), 32'h0000);
    chk("c6_y_ovf", 32'(y_ovf), 32'd0);
    chk("c6_addr_cnt", 32'(addr_q.size()), 32'd28);
    for (int i = 0; i < addr_q.size() && i < 28; i++) begin
      chk($sformatf("c6_addr_%0d", i), 32'(addr_q[i]), 32'(i));
    end
    accept_y();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
